// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// arbitration mode encoding and the beat-counter width helper.
package mux2_arb_pkg;

   typedef enum logic {
      MODE_FREE   = 1'b0,
      MODE_LOCKED = 1'b1
   } mode_e;

   // Enough bits to hold a count that saturates at max_beats.
   function automatic int beat_cnt_w(input int max_beats);
      return $clog2(max_beats + 1);
   endfunction

endpackage

// File: rtl/mux2_ands.sv
// One bit lane of the shared bus: 2:1 mux followed by an AND enable,
// matching a 74LVC1G157 feeding a 74LVC1G08.
module mux2_ands (
   input  logic [1:0] i_i,
   input  logic       s_i,
   input  logic       b_i,
   output logic       y_o
);

   assign y_o = b_i & (s_i ? i_i[1] : i_i[0]);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one gated 2:1 mux datapath between two
// valid/ready sources; grant locks across stalls and multi-beat packets.
module mux2_rr_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       req_valid_i,
   input  logic [1:0]       req_last_i,
   input  logic [WIDTH-1:0] req0_data_i,
   input  logic [WIDTH-1:0] req1_data_i,
   output logic [1:0]       req_ready_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_sel_o,
   input  logic             out_ready_i,
   output logic             err_o
);

   localparam int              BW        = beat_cnt_w(MAX_BEATS);
   localparam logic [BW-1:0]   BEAT_SAT  = BW'(MAX_BEATS);
   localparam logic [BW-1:0]   BEAT_WARN = BW'(MAX_BEATS - 1);

   mode_e         mode_q, mode_d;
   logic          gnt_q, gnt_d;
   logic          prio_q, prio_d;
   logic          err_q, err_d;
   logic [BW-1:0] beat_q, beat_d;

   logic sel;
   logic hs;
   logic last;

   // Select depends only on registered state and valids, never on out_ready_i.
   always_comb begin
      sel = prio_q;
      if (mode_q == MODE_LOCKED) begin
         sel = gnt_q;
      end else begin
         case (req_valid_i)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            default: sel = prio_q;
         endcase
      end
   end

   assign out_sel_o   = sel & ~rst_i;
   assign out_valid_o = req_valid_i[sel] & ~rst_i;
   assign req_ready_o = (out_ready_i & ~rst_i) ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign err_o       = err_q & ~rst_i;

   assign hs   = out_valid_o & out_ready_i;
   assign last = req_last_i[sel];

   always_comb begin
      mode_d = mode_q;
      gnt_d  = gnt_q;
      prio_d = prio_q;
      err_d  = err_q;
      beat_d = beat_q;
      case (mode_q)
         MODE_FREE: begin
            if (out_valid_o && (!out_ready_i || !last)) begin
               mode_d = MODE_LOCKED;
               gnt_d  = sel;
            end
         end
         default: begin
            if (hs && last) mode_d = MODE_FREE;
         end
      endcase
      if (hs) begin
         if (last) begin
            prio_d = ~sel;
            beat_d = '0;
         end else begin
            if (beat_q == BEAT_WARN) err_d = 1'b1;
            if (beat_q != BEAT_SAT) beat_d = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q <= MODE_FREE;
         gnt_q  <= 1'b0;
         prio_q <= 1'b0;
         err_q  <= 1'b0;
         beat_q <= '0;
      end else begin
         mode_q <= mode_d;
         gnt_q  <= gnt_d;
         prio_q <= prio_d;
         err_q  <= err_d;
         beat_q <= beat_d;
      end
   end

   for (genvar k = 0; k < WIDTH; k++) begin : g_lane
      mux2_ands u_lane (
         .i_i ({req1_data_i[k], req0_data_i[k]}),
         .s_i (out_sel_o),
         .b_i (out_valid_o),
         .y_o (out_data_o[k])
      );
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios with literal expectations,
// then random traffic compared each cycle against a packet-level model.
module tb_mux2_rr_arbiter;

   localparam int W  = 8;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_last;
   logic [W-1:0] d0, d1;
   logic [1:0]   req_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_sel;
   logic         out_ready;
   logic         err;

   int checks = 0;
   int errors = 0;

   // Packet-level model: owner is the requester mid-packet, -1 when none.
   int owner = -1;
   int pref  = 0;
   int beats = 0;
   bit merr  = 1'b0;

   mux2_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_last_i  (req_last),
      .req0_data_i (d0),
      .req1_data_i (d1),
      .req_ready_o (req_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_sel_o   (out_sel),
      .out_ready_i (out_ready),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_sel();
      if (owner >= 0) return owner;
      if (req_valid == 2'b01) return 0;
      if (req_valid == 2'b10) return 1;
      return pref;
   endfunction

   // Compare process: every cycle, outputs versus model.
   always @(negedge clk) begin
      int s;
      logic ev;
      logic [W-1:0] ed;
      if (rst) begin
         chk("m_valid", {31'd0, out_valid}, 0);
         chk("m_ready", {30'd0, req_ready}, 0);
         chk("m_data",  {24'd0, out_data}, 0);
         chk("m_sel",   {31'd0, out_sel}, 0);
         chk("m_err",   {31'd0, err}, 0);
      end else begin
         s  = model_sel();
         ev = req_valid[s];
         ed = ev ? (s == 1 ? d1 : d0) : '0;
         chk("m_sel",   {31'd0, out_sel}, s);
         chk("m_valid", {31'd0, out_valid}, {31'd0, ev});
         chk("m_data",  {24'd0, out_data}, {24'd0, ed});
         chk("m_ready", {30'd0, req_ready}, out_ready ? (s == 1 ? 2 : 1) : 0);
         chk("m_err",   {31'd0, err}, {31'd0, merr});
      end
   end

   always @(posedge clk) begin
      int s;
      if (rst) begin
         owner = -1;
         pref  = 0;
         beats = 0;
         merr  = 1'b0;
      end else begin
         s = model_sel();
         if (req_valid[s] && out_ready) begin
            if (req_last[s]) begin
               beats = 0;
               pref  = 1 - s;
               owner = -1;
            end else begin
               if (beats == MB - 1) merr = 1'b1;
               if (beats < MB) beats++;
               owner = s;
            end
         end else if (req_valid[s]) begin
            owner = s;
         end
      end
   end

   task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] l,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic rd);
      @(posedge clk);
      #1;
      rst = r; req_valid = v; req_last = l; d0 = a; d1 = b; out_ready = rd;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; req_last = 2'b00; d0 = '0; d1 = '0; out_ready = 1'b0;

      // Reset: all outputs held low.
      cyc(1'b1, 2'b11, 2'b11, 8'hA5, 8'h3C, 1'b1);
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_ready", {30'd0, req_ready}, 0);
      chk("rst_data",  {24'd0, out_data}, 0);
      chk("rst_sel",   {31'd0, out_sel}, 0);
      chk("rst_err",   {31'd0, err}, 0);

      // Both requesting single-beat packets: strict alternation.
      cyc(1'b0, 2'b11, 2'b11, 8'hA5, 8'h3C, 1'b1);
      chk("alt0", {24'd0, out_data}, 32'hA5);
      cyc(1'b0, 2'b11, 2'b11, 8'hA5, 8'h3C, 1'b1);
      chk("alt1", {24'd0, out_data}, 32'h3C);
      cyc(1'b0, 2'b11, 2'b11, 8'hA5, 8'h3C, 1'b1);
      chk("alt2", {24'd0, out_data}, 32'hA5);
      cyc(1'b0, 2'b10, 2'b10, 8'h00, 8'h3C, 1'b1);

      // Three-beat packet from requester 0 holds the grant.
      cyc(1'b0, 2'b11, 2'b00, 8'h01, 8'h55, 1'b1);
      chk("pkt_sel1", {31'd0, out_sel}, 0);
      chk("pkt_d1",   {24'd0, out_data}, 32'h01);
      cyc(1'b0, 2'b11, 2'b00, 8'h02, 8'h55, 1'b1);
      chk("pkt_sel2", {31'd0, out_sel}, 0);
      chk("pkt_d2",   {24'd0, out_data}, 32'h02);
      cyc(1'b0, 2'b11, 2'b01, 8'h03, 8'h55, 1'b1);
      chk("pkt_sel3", {31'd0, out_sel}, 0);
      chk("pkt_d3",   {24'd0, out_data}, 32'h03);

      // Stall on requester 1; requester 0 joins mid-stall.
      cyc(1'b0, 2'b10, 2'b10, 8'h11, 8'h77, 1'b0);
      chk("stall_sel0", {31'd0, out_sel}, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 2'b11, 2'b11, 8'h11, 8'h77, 1'b0);
         chk("stall_sel",  {31'd0, out_sel}, 1);
         chk("stall_data", {24'd0, out_data}, 32'h77);
         chk("stall_rdy",  {30'd0, req_ready}, 0);
      end
      cyc(1'b0, 2'b11, 2'b11, 8'h11, 8'h77, 1'b1);
      chk("stall_hs_data", {24'd0, out_data}, 32'h77);
      chk("stall_hs_rdy",  {30'd0, req_ready}, 2);

      // Idle.
      cyc(1'b0, 2'b00, 2'b00, 8'h99, 8'h66, 1'b1);
      chk("idle_valid", {31'd0, out_valid}, 0);
      chk("idle_data",  {24'd0, out_data}, 0);
      chk("idle_rdy1",  {31'd0, req_ready[1]}, 0);

      // Six-beat packet against a four-beat limit.
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b0, 2'b01, (k == 6) ? 2'b01 : 2'b00, W'(k), 8'h00, 1'b1);
         chk("ovr_data", {24'd0, out_data}, k);
         chk("ovr_err",  {31'd0, err}, (k >= 5) ? 1 : 0);
      end
      cyc(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
      chk("ovr_sticky", {31'd0, err}, 1);

      // Reset in the middle of a locked packet.
      cyc(1'b0, 2'b10, 2'b00, 8'h21, 8'h42, 1'b1);
      chk("rstmid_sel", {31'd0, out_sel}, 1);
      cyc(1'b1, 2'b10, 2'b00, 8'h21, 8'h43, 1'b1);
      chk("rstmid_valid", {31'd0, out_valid}, 0);
      cyc(1'b0, 2'b11, 2'b11, 8'h21, 8'h44, 1'b1);
      chk("rstmid_prio", {31'd0, out_sel}, 0);
      chk("rstmid_data", {24'd0, out_data}, 32'h21);
      chk("rstmid_err",  {31'd0, err}, 0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 63) == 0),
             2'($urandom_range(0, 3)),
             {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
             W'($urandom), W'($urandom),
             ($urandom_range(0, 3) != 0));
      end

      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester round-robin arbiter that shares one gated 2:1 mux datapath (a mux with a downstream AND enable) between two valid/ready sources. It generates the mux select and the AND enable, and locks the grant for stalled beats and multi-beat packets. It sits in front of any shared bus segment built from 74LVC1G157/74LVC1G08 lanes. It also flags packets that exceed a length limit.

## Interface
- WIDTH, default 8: data width per requester and output.
- MAX_BEATS, default 16: packet-length limit for the overrun flag, ≥1.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  2  per-requester valid; bit n = requester n.
- req_last_i  in  2  per-requester last beat of packet.
- req0_data_i  in  WIDTH  requester 0 data.
- req1_data_i  in  WIDTH  requester 1 data.
- req_ready_o  out  2  per-requester ready.
- out_valid_o  out  1  shared output valid.
- out_data_o  out  WIDTH  gated mux output; 0 when out_valid_o = 0.
- out_sel_o  out  1  current mux select (granted requester).
- out_ready_i  in  1  downstream ready.
- err_o  out  1  sticky packet-overrun flag.

## Operation
- State: mode_q ∈ {FREE, LOCKED}; gnt_q (1 b, locked owner); prio_q (1 b, preferred requester); beat_q (width $clog2(MAX_BEATS+1)); err_q.
- FREE arbitration: only one valid → that one; both valid → prio_q; none → out_sel_o = prio_q.
- LOCKED: select = gnt_q regardless of the other requester's valid.
- out_valid_o = req_valid_i[sel]. out_data_o = out_valid_o AND mux(sel). req_ready_o[sel] = out_ready_i; req_ready_o[~sel] = 0.
- Handshake = out_valid_o & out_ready_i.
- FREE → LOCKED: out_valid_o & (~out_ready_i | ~req_last_i[sel]). gnt_q ← sel.
- LOCKED → FREE: handshake with req_last_i[gnt_q] = 1.
- FREE and the handshake carries last: stay FREE.
- prio_q ← ~sel on every handshake with last = 1. Otherwise prio_q holds.
- beat_q counts accepted beats of the current packet. It clears on a last-beat handshake and saturates at MAX_BEATS.
- A non-last handshake with beat_q = MAX_BEATS−1 sets err_q. err_q clears only on reset. The lock is never force-released.
- A locked requester that drops valid mid-packet yields out_valid_o = 0. The grant stays with it until it delivers a last beat.
- Reset mid-packet: the packet is abandoned. mode_q = FREE, prio_q = 0, beat_q = 0, err_q = 0.

## Timing
- Data/valid/ready path is combinational: zero-cycle latency, no pipeline register.
- State updates on the rising clk_i edge. A grant decision taken in FREE becomes registered in gnt_q the next cycle.
- Outputs while rst_i = 1: out_valid_o = 0, req_ready_o = 0, out_data_o = 0, out_sel_o = 0, err_o = 0.
- Grant never changes while out_valid_o = 1 and out_ready_i = 0, which keeps data stable under stall.
- No combinational path from out_ready_i to out_valid_o or out_sel_o.
- Simultaneous last-beat handshake and new request from the other requester: that requester wins the next cycle, because prio_q has flipped.

## Structure
- Shared package mux2_arb_pkg holds: the mode enum (FREE = 1'b0, LOCKED = 1'b1) and a beat-counter width function.
- Datapath: WIDTH instances of the existing mux2_ands cell macro.
  - i_i = {req1_data_i[k], req0_data_i[k]}, s_i = out_sel_o, b_i = out_valid_o.
- The arbiter FSM is coded inline; no further sub-modules.

## Test plan
- Reset, then req_valid_i = 2'b11, both last, out_ready_i = 1, data 0xA5/0x3C → out_data_o 0xA5, then 0x3C, then 0xA5 (alternating).
- Requester 0 sends a 3-beat packet 0x01/0x02/0x03 (last on the third); requester 1 valid throughout → out_sel_o = 0 for all three beats, then requester 1 granted.
- out_ready_i = 0 for 4 cycles with requester 1 valid and data 0x77; requester 0 asserts valid mid-stall → out_sel_o stays 1 and out_data_o stays 0x77 until the handshake.
- No valid → out_valid_o = 0, out_data_o = 0x00, req_ready_o = 0 on the idle side.
- MAX_BEATS = 4: a 6-beat packet → err_o rises the cycle after the 4th non-last beat and stays 1 after the packet ends.
- rst_i asserted during beat 2 of a locked packet → next cycle mode FREE, err_o = 0, requester 0 has priority.
